// File: rtl/tri_bus_reader.sv
// Reader side of the shared tri-state result bus: grants one driver at a
// time, samples the resolved bus and forwards each word on valid/ready.
module tri_bus_reader #(
  parameter int N_DRV = 4,
  parameter int WIDTH = 8,
  parameter int TURN  = 1,
  localparam int SRC_W = (N_DRV > 1) ? $clog2(N_DRV) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_DRV-1:0] en_mask,
  output logic [N_DRV-1:0] dir,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] rd_data,
  output logic [SRC_W-1:0] rd_src,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_SAMPLE,
    S_HOLD,
    S_TURN
  } state_t;

  function automatic logic [SRC_W-1:0] lowest(
    input logic [N_DRV-1:0] v
  );
    lowest = '0;
    for (int i = N_DRV - 1; i >= 0; i--)
      if (v[i]) lowest = SRC_W'(i);
  endfunction

  function automatic logic [N_DRV-1:0] onehot(
    input logic [SRC_W-1:0] i
  );
    onehot = N_DRV'(1) << i;
  endfunction

  state_t           state_q, state_n;
  logic [SRC_W-1:0] idx_q, idx_n;
  logic [N_DRV-1:0] rem_q, rem_n;
  logic [2:0]       cnt_q, cnt_n;
  logic [N_DRV-1:0] dir_n;
  logic [WIDTH-1:0] data_n;
  logic [SRC_W-1:0] src_n;
  logic             valid_n;
  logic             done_n;
  logic             adv;
  logic [SRC_W-1:0] first_idx;
  logic [SRC_W-1:0] nxt_idx;

  assign first_idx = lowest(en_mask);
  assign nxt_idx   = lowest(rem_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      dir      <= '0;
      rd_data  <= '0;
      rd_src   <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_n;
      idx_q    <= idx_n;
      rem_q    <= rem_n;
      cnt_q    <= cnt_n;
      dir      <= dir_n;
      rd_data  <= data_n;
      rd_src   <= src_n;
      rd_valid <= valid_n;
      busy     <= (state_n != S_IDLE);
      done     <= done_n;
    end
  end

  // rem_q holds the not-yet-visited drivers; each grant clears its bit
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    rem_n   = rem_q;
    cnt_n   = cnt_q;
    dir_n   = dir;
    data_n  = rd_data;
    src_n   = rd_src;
    valid_n = rd_valid;
    done_n  = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !done && en_mask != '0) begin
          state_n = S_GRANT;
          idx_n   = first_idx;
          rem_n   = en_mask & ~onehot(first_idx);
          dir_n   = onehot(first_idx);
        end
      end
      S_GRANT: state_n = S_SAMPLE;
      S_SAMPLE: begin
        data_n  = bus_in;
        src_n   = idx_q;
        valid_n = 1'b1;
        dir_n   = '0;
        state_n = S_HOLD;
      end
      S_HOLD: begin
        if (rd_valid && rd_ready) begin
          valid_n = 1'b0;
          if (TURN > 0) begin
            state_n = S_TURN;
            cnt_n   = 3'(TURN - 1);
          end else begin
            adv = 1'b1;
          end
        end
      end
      S_TURN: begin
        if (cnt_q == '0) adv = 1'b1;
        else cnt_n = cnt_q - 3'd1;
      end
      default: state_n = S_IDLE;
    endcase
    if (adv) begin
      if (rem_q != '0) begin
        state_n = S_GRANT;
        idx_n   = nxt_idx;
        rem_n   = rem_q & ~onehot(nxt_idx);
        dir_n   = onehot(nxt_idx);
      end else begin
        state_n = S_IDLE;
        done_n  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tri_bus_reader.sv
// Directed bench for tri_bus_reader: scoreboard of expected words,
// handshake/grant timing, back-pressure, reset and turnaround gaps.
module tb_tri_bus_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] en_mask;
  logic [3:0] dir;
  logic [7:0] bus_in;
  logic [7:0] rd_data;
  logic [1:0] rd_src;
  logic       rd_valid;
  logic       rd_ready;
  logic       busy;
  logic       done;

  logic [7:0] da [4];
  logic [7:0] db [4];

  logic       start6;
  logic [3:0] mask6;
  logic [7:0] bus6;
  logic       rdy6;
  logic [3:0] dir_t0, dir_t3;
  logic [7:0] data_t0, data_t3;
  logic [1:0] src_t0, src_t3;
  logic       val_t0, val_t3;
  logic       busy_t0, busy_t3;
  logic       done_t0, done_t3;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [9:0] sbq [$];
  int wt [$];
  int gaps0 [$];
  int gaps3 [$];
  int z0 = 0, z3 = 0;
  bit seen0 = 0, seen3 = 0;

  always #5 clk = ~clk;

  tri_bus_reader #(.N_DRV(4), .WIDTH(8), .TURN(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .en_mask(en_mask),
    .dir(dir), .bus_in(bus_in), .rd_data(rd_data), .rd_src(rd_src),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .busy(busy), .done(done)
  );

  tri_bus_reader #(.N_DRV(4), .WIDTH(8), .TURN(0)) u_t0 (
    .clk(clk), .rst_n(rst_n), .start(start6), .en_mask(mask6),
    .dir(dir_t0), .bus_in(bus6), .rd_data(data_t0), .rd_src(src_t0),
    .rd_valid(val_t0), .rd_ready(rdy6), .busy(busy_t0), .done(done_t0)
  );

  tri_bus_reader #(.N_DRV(4), .WIDTH(8), .TURN(3)) u_t3 (
    .clk(clk), .rst_n(rst_n), .start(start6), .en_mask(mask6),
    .dir(dir_t3), .bus_in(bus6), .rd_data(data_t3), .rd_src(src_t3),
    .rd_valid(val_t3), .rd_ready(rdy6), .busy(busy_t3), .done(done_t3)
  );

  // XOR drivers resolved onto the bus; EE marks an undriven bus
  always_comb begin
    bus_in = 8'hEE;
    for (int i = 0; i < 4; i++)
      if (dir[i]) bus_in = da[i] ^ db[i];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [9:0] e;
    if (rst_n) begin
      check("onehot0", 32'($onehot0(dir)), 32'd1);
      if (rd_valid && rd_ready) begin
        wt.push_back(cyc);
        if (sbq.size() == 0) begin
          check("unexp_word", {22'd0, rd_src, rd_data}, 32'hFFFF_FFFF);
        end else begin
          e = sbq.pop_front();
          check("word", {22'd0, rd_src, rd_data}, {22'd0, e});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (dir_t0 != 4'd0) begin
      if (seen0 && z0 > 0) gaps0.push_back(z0);
      seen0 = 1; z0 = 0;
    end else if (seen0) z0++;
    if (dir_t3 != 4'd0) begin
      if (seen3 && z3 > 0) gaps3.push_back(z3);
      seen3 = 1; z3 = 0;
    end else if (seen3) z3++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sweep(input logic [3:0] m);
    for (int i = 0; i < 4; i++)
      if (m[i]) sbq.push_back({2'(i), da[i] ^ db[i]});
  endtask

  task automatic pulse_start(input logic [3:0] m);
    en_mask = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; en_mask = 4'd0; rd_ready = 1'b1;
    start6 = 1'b0; mask6 = 4'hF; bus6 = 8'h00; rdy6 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      da[i] = 8'd0; db[i] = 8'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_dir", 32'(dir), 32'd0);
    check("rst_out", {21'd0, rd_data, rd_src, rd_valid}, 32'd0);
    check("rst_bd", {30'd0, busy, done}, 32'd0);
    rst_n = 1'b1;
    tick();

    // T1 single driver
    da[2] = 8'h01; db[2] = 8'h00;
    push_sweep(4'b0100);
    pulse_start(4'b0100);
    check("t1_grant", 32'(dir), 32'h4);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    check("t1_sample", 32'(dir), 32'h4);
    check("t1_valid0", 32'(rd_valid), 32'd0);
    tick();
    check("t1_dir_rel", 32'(dir), 32'd0);
    check("t1_word", {22'd0, rd_src, rd_data}, {22'd0, 2'd2, 8'h01});
    check("t1_valid", 32'(rd_valid), 32'd1);
    tick();
    check("t1_turn", {30'd0, rd_valid, done}, 32'd0);
    tick();
    check("t1_done", {30'd0, busy, done}, 32'b01);
    tick();
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_sbq", 32'(sbq.size()), 32'd0);

    // T2 full sweep
    da[0] = 8'hF0; db[0] = 8'h55;
    da[1] = 8'h0F; db[1] = 8'h55;
    da[2] = 8'hFF; db[2] = 8'h00;
    da[3] = 8'h3C; db[3] = 8'h3C;
    wt.delete();
    push_sweep(4'b1111);
    pulse_start(4'b1111);
    wait_idle("t2_idle");
    check("t2_nwords", 32'(wt.size()), 32'd4);
    for (int k = 1; k < wt.size(); k++)
      check("t2_interval", 32'(wt[k] - wt[k-1]), 32'd4);
    check("t2_sbq", 32'(sbq.size()), 32'd0);

    // T3 back-pressure
    da[0] = 8'h3C; db[0] = 8'h0F;
    da[1] = 8'h81; db[1] = 8'h18;
    rd_ready = 1'b0;
    push_sweep(4'b0011);
    pulse_start(4'b0011);
    begin
      int n = 0;
      while (!rd_valid && n < 20) begin
        tick();
        n++;
      end
    end
    check("t3_valid", 32'(rd_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      check("t3_hold", {22'd0, rd_valid, rd_src, rd_data},
            {22'd0, 1'b1, 2'd0, 8'h33});
      check("t3_dir", 32'(dir), 32'd0);
      tick();
    end
    rd_ready = 1'b1;
    tick();
    check("t3_turn_dir", 32'(dir), 32'd0);
    check("t3_turn_valid", 32'(rd_valid), 32'd0);
    tick();
    check("t3_regrant", 32'(dir), 32'h2);
    wait_idle("t3_idle");
    check("t3_sbq", 32'(sbq.size()), 32'd0);

    // T4 empty mask, start while busy, mask change mid-sweep
    en_mask = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_empty", {30'd0, busy, done}, 32'd0);
    tick();
    check("t4_empty2", {30'd0, busy, done}, 32'd0);
    da[0] = 8'hA0; db[0] = 8'h05;
    da[3] = 8'h77; db[3] = 8'h00;
    push_sweep(4'b1001);
    en_mask = 4'b1001;
    start = 1'b1;
    tick();
    en_mask = 4'b0110;
    check("t4_grant", 32'(dir), 32'h1);
    begin
      int n = 0;
      while (!done && n < 100) begin
        tick();
        n++;
      end
    end
    check("t4_done", 32'(done), 32'd1);
    tick();
    start = 1'b0;
    check("t4_start_on_done", 32'(busy), 32'd0);
    check("t4_sbq", 32'(sbq.size()), 32'd0);
    tick();

    // T5 reset during SAMPLE, then during HOLD
    da[0] = 8'h12; db[0] = 8'h00;
    push_sweep(4'b0001);
    pulse_start(4'b0001);
    tick();
    check("t5_sample", 32'(dir), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_dir_async", 32'(dir), 32'd0);
    check("t5_vb_async", {30'd0, rd_valid, busy}, 32'd0);
    sbq.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    rd_ready = 1'b0;
    push_sweep(4'b0001);
    pulse_start(4'b0001);
    tick();
    tick();
    check("t5_hold_valid", 32'(rd_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_valid_async", 32'(rd_valid), 32'd0);
    check("t5_data_async", {22'd0, rd_src, rd_data}, 32'd0);
    sbq.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    rd_ready = 1'b1;
    tick();
    da[1] = 8'h5D; db[1] = 8'h00;
    push_sweep(4'b0010);
    pulse_start(4'b0010);
    wait_idle("t5_idle");
    check("t5_sbq", 32'(sbq.size()), 32'd0);

    // T6 turnaround gaps for TURN=0 and TURN=3
    start6 = 1'b1;
    tick();
    start6 = 1'b0;
    begin
      int n = 0;
      while ((busy_t0 || busy_t3) && n < 100) begin
        tick();
        n++;
      end
    end
    check("t6_idle", {30'd0, busy_t0, busy_t3}, 32'd0);
    check("t6_ngaps0", 32'(gaps0.size()), 32'd3);
    check("t6_ngaps3", 32'(gaps3.size()), 32'd3);
    for (int k = 0; k < gaps0.size(); k++)
      check("t6_gap_turn0", 32'(gaps0[k]), 32'd1);
    for (int k = 0; k < gaps3.size(); k++)
      check("t6_gap_turn3", 32'(gaps3[k]), 32'd4);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
